// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared MIPS opcode/funct constants, fetch state and next-PC select types
// Shared by fetch_sequencer, next_pc_calc, the decoder and the jump-detect logic.
package mips_defs;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes, instr[5:0]
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_HALT    = 2'd3
    } fetch_state_e;

    typedef enum logic [2:0] {
        NPC_SEQ      = 3'd0,
        NPC_JUMP     = 3'd1,
        NPC_BR_TAKEN = 3'd2,
        NPC_BR_NOT   = 3'd3,
        NPC_JR       = 3'd4
    } npc_sel_e;

    // True for every opcode/funct combination the core executes.
    function automatic logic is_supported(input logic [31:0] instr);
        logic ok;
        ok = 1'b0;
        case (instr[31:26])
            OP_RTYPE: ok = (instr[5:0] == FN_JR)  || (instr[5:0] == FN_ADD) ||
                           (instr[5:0] == FN_SUB) || (instr[5:0] == FN_SLT);
            OP_J, OP_JAL, OP_BEQ, OP_BNE,
            OP_ADDI, OP_XORI, OP_LW, OP_SW: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic is_branch(input logic [31:0] instr);
        return (instr[31:26] == OP_BEQ) || (instr[31:26] == OP_BNE);
    endfunction

    function automatic logic is_jr(input logic [31:0] instr);
        return (instr[31:26] == OP_RTYPE) && (instr[5:0] == FN_JR);
    endfunction

    function automatic logic is_jump(input logic [31:0] instr);
        return (instr[31:26] == OP_J) || (instr[31:26] == OP_JAL);
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC target generation and source select
// Ports:
//   instr_pc      PC of the instruction being resolved
//   instr         instruction word being resolved
//   jr_target     register-file target for JR
//   select        which target drives next_pc
//   seq_target    instr_pc + PC_STEP
//   link_target   instr_pc + 4 (link address / branch fall-through)
//   jump_target   J/JAL region target
//   branch_target taken BEQ/BNE target
//   jr_aligned    JR target with the low two bits cleared
//   next_pc       target chosen by select
import mips_defs::*;

module next_pc_calc #(
    parameter logic [31:0] PC_STEP = 32'd4
) (
    input  logic [31:0] instr_pc,
    input  logic [31:0] instr,
    input  logic [31:0] jr_target,
    input  npc_sel_e    select,
    output logic [31:0] seq_target,
    output logic [31:0] link_target,
    output logic [31:0] jump_target,
    output logic [31:0] branch_target,
    output logic [31:0] jr_aligned,
    output logic [31:0] next_pc
);

    logic [31:0] br_offset;

    // Sign-extended word offset, already shifted to a byte offset.
    assign br_offset     = {{14{instr[15]}}, instr[15:0], 2'b00};

    assign seq_target    = instr_pc + PC_STEP;
    assign link_target   = instr_pc + 32'd4;
    assign jump_target   = {link_target[31:28], instr[25:0], 2'b00};
    assign branch_target = link_target + br_offset;
    assign jr_aligned    = {jr_target[31:2], 2'b00};

    always_comb begin
        next_pc = seq_target;
        case (select)
            NPC_SEQ:      next_pc = seq_target;
            NPC_JUMP:     next_pc = jump_target;
            NPC_BR_TAKEN: next_pc = branch_target;
            NPC_BR_NOT:   next_pc = link_target;
            NPC_JR:       next_pc = jr_aligned;
            default:      next_pc = seq_target;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - multi-cycle fetch / next-PC controller owning the program counter
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   imem_req/addr/ack/rdata instruction-memory read handshake
//   instr_out/pc/valid/ready instruction handoff to decode
//   br_valid/br_taken       resolved BEQ/BNE outcome from execute
//   jr_valid/jr_target      JR register target from the register file
//   link_we/link_addr       one-cycle $31 write for JAL
//   illegal_op              sticky unsupported-instruction flag
import mips_defs::*;

module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic        jr_valid,
    input  logic [31:0] jr_target,
    output logic        link_we,
    output logic [31:0] link_addr,
    output logic        illegal_op
);

    localparam logic [1:0] S_FETCH   = ST_FETCH;
    localparam logic [1:0] S_ISSUE   = ST_ISSUE;
    localparam logic [1:0] S_RESOLVE = ST_RESOLVE;
    localparam logic [1:0] S_HALT    = ST_HALT;

    logic [1:0]  state_q,     state_d;
    logic [31:0] pc_q,        pc_d;
    logic [31:0] instr_q,     instr_d;
    logic [31:0] instr_pc_q,  instr_pc_d;
    logic        imem_req_q,  imem_req_d;
    logic        link_we_q,   link_we_d;
    logic [31:0] link_addr_q, link_addr_d;
    logic        illegal_q,   illegal_d;

    npc_sel_e    npc_sel;
    logic [31:0] seq_target;
    logic [31:0] link_target;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [31:0] jr_aligned;
    logic [31:0] next_pc;

    next_pc_calc #(
        .PC_STEP (32'(PC_STEP))
    ) u_next_pc_calc (
        .instr_pc      (instr_pc_q),
        .instr         (instr_q),
        .jr_target     (jr_target),
        .select        (npc_sel),
        .seq_target    (seq_target),
        .link_target   (link_target),
        .jump_target   (jump_target),
        .branch_target (branch_target),
        .jr_aligned    (jr_aligned),
        .next_pc       (next_pc)
    );

    // Source select depends only on registered state and the branch outcome,
    // so it is kept apart from the main transition logic.
    always_comb begin
        npc_sel = NPC_SEQ;
        case (state_q)
            S_ISSUE: begin
                if (is_jump(instr_q)) begin
                    npc_sel = NPC_JUMP;
                end
            end
            S_RESOLVE: begin
                if (is_branch(instr_q)) begin
                    npc_sel = br_taken ? NPC_BR_TAKEN : NPC_BR_NOT;
                end else begin
                    npc_sel = NPC_JR;
                end
            end
            default: npc_sel = NPC_SEQ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        link_we_d   = 1'b0;
        link_addr_d = link_addr_q;
        illegal_d   = illegal_q;

        case (state_q)
            S_FETCH: begin
                // An ack only counts against a request actually on the bus.
                if (imem_req_q && imem_ack) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    // Screening here means an unsupported word never shows valid.
                    if (is_supported(imem_rdata)) begin
                        state_d = S_ISSUE;
                    end else begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                end
            end
            S_ISSUE: begin
                if (instr_ready) begin
                    if (is_branch(instr_q) || is_jr(instr_q)) begin
                        state_d = S_RESOLVE;
                    end else begin
                        pc_d    = next_pc;
                        state_d = S_FETCH;
                        if (instr_q[31:26] == OP_JAL) begin
                            link_we_d   = 1'b1;
                            link_addr_d = link_target;
                        end
                    end
                end
            end
            S_RESOLVE: begin
                // Only the resolution input matching the pending class is looked at.
                if (is_branch(instr_q) ? br_valid : jr_valid) begin
                    pc_d    = next_pc;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_HALT;
        endcase

        // Request is raised for the first cycle after entering FETCH and held until ack.
        imem_req_d = (state_d == S_FETCH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            instr_q     <= 32'd0;
            instr_pc_q  <= 32'd0;
            imem_req_q  <= 1'b0;
            link_we_q   <= 1'b0;
            link_addr_q <= 32'd0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            imem_req_q  <= imem_req_d;
            link_we_q   <= link_we_d;
            link_addr_q <= link_addr_d;
            illegal_q   <= illegal_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr_out   = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = (state_q == S_ISSUE);
    assign link_we     = link_we_q;
    assign link_addr   = link_addr_q;
    assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    localparam logic [31:0] W_ADDI  = 32'h2001_0005;
    localparam logic [31:0] W_JAL   = 32'h0C00_0010;
    localparam logic [31:0] W_J400  = 32'h0810_0002;
    localparam logic [31:0] W_J100  = 32'h0800_0040;
    localparam logic [31:0] W_BEQ   = 32'h1000_FFFE;
    localparam logic [31:0] W_JR    = 32'h03E0_0008;
    localparam logic [31:0] W_ILL   = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        br_valid;
    logic        br_taken;
    logic        jr_valid;
    logic [31:0] jr_target;
    logic        link_we;
    logic [31:0] link_addr;
    logic        illegal_op;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_word_q[$];

    always #5 clk = ~clk;

    fetch_sequencer #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .br_valid    (br_valid),
        .br_taken    (br_taken),
        .jr_valid    (jr_valid),
        .jr_target   (jr_target),
        .link_we     (link_we),
        .link_addr   (link_addr),
        .illegal_op  (illegal_op)
    );

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Waits for a request, holds off the ack for 'delay' cycles, checks the
    // address against the scoreboard and returns 'word'.
    task automatic fetch_word(input logic [31:0] word, input int delay);
        bit          ok;
        logic [31:0] ea;
        wait_req(ok);
        total++;
        if (!ok || exp_addr_q.size() == 0) begin
            bad++;
            $display("FAIL fetch_req: req=%b pending=%0d required req=1 with expectation", imem_req, exp_addr_q.size());
            return;
        end
        ea = exp_addr_q.pop_front();
        repeat (delay) @(negedge clk);
        total++;
        if (imem_addr !== ea || imem_req !== 1'b1) begin
            bad++;
            $display("FAIL fetch_addr: addr=%h req=%b required addr=%h req=1", imem_addr, imem_req, ea);
        end
        exp_pc_q.push_back(ea);
        exp_word_q.push_back(word);
        imem_rdata = word;
        imem_ack   = 1'b1;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
    endtask

    task automatic accept_instr(input int stall);
        bit          ok;
        logic [31:0] epc, ew;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!ok || exp_pc_q.size() == 0) begin
            bad++;
            $display("FAIL issue_valid: valid=%b required 1", instr_valid);
            return;
        end
        epc = exp_pc_q.pop_front();
        ew  = exp_word_q.pop_front();
        total++;
        if (instr_pc !== epc || instr_out !== ew) begin
            bad++;
            $display("FAIL issue_word: pc=%h instr=%h required pc=%h instr=%h", instr_pc, instr_out, epc, ew);
        end
        for (int i = 0; i < stall; i++) begin
            instr_ready = 1'b0;
            @(negedge clk);
            total++;
            if (instr_valid !== 1'b1 || instr_out !== ew || instr_pc !== epc || imem_req !== 1'b0) begin
                bad++;
                $display("FAIL backpressure: valid=%b instr=%h pc=%h req=%b required 1 %h %h 0",
                         instr_valid, instr_out, instr_pc, imem_req, ew, epc);
            end
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || link_we !== 1'b0 || illegal_op !== 1'b0 ||
            imem_addr !== 32'd0 || instr_out !== 32'd0 || instr_pc !== 32'd0 || link_addr !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: req=%b valid=%b lwe=%b ill=%b addr=%h out=%h pc=%h link=%h required all 0",
                     imem_req, instr_valid, link_we, illegal_op, imem_addr, instr_out, instr_pc, link_addr);
        end
        // Ack with no request outstanding right after release must be ignored.
        reset_n    = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = W_ILL;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        total++;
        if (illegal_op !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            bad++;
            $display("FAIL stray_ack: ill=%b req=%b addr=%h required ill=0 req=1 addr=0", illegal_op, imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential;
        for (int i = 0; i < 4; i++) exp_addr_q.push_back(32'(i * 4));
        for (int i = 0; i < 4; i++) begin
            fetch_word(W_ADDI, 2);
            accept_instr(0);
        end
        total++;
        if (illegal_op !== 1'b0) begin
            bad++;
            $display("FAIL seq_illegal: ill=%b required 0", illegal_op);
        end
    endtask

    task automatic test_jal;
        exp_addr_q.push_back(32'h0000_0010);
        fetch_word(W_J400, 1);
        accept_instr(0);
        exp_addr_q.push_back(32'h0040_0008);
        fetch_word(W_JAL, 0);
        accept_instr(0);
        total++;
        if (link_we !== 1'b1 || link_addr !== 32'h0040_000C) begin
            bad++;
            $display("FAIL jal_link: we=%b addr=%h required we=1 addr=0040000c", link_we, link_addr);
        end
        @(negedge clk);
        total++;
        if (link_we !== 1'b0) begin
            bad++;
            $display("FAIL jal_pulse: we=%b required 0", link_we);
        end
        exp_addr_q.push_back(32'h0000_0040);
        fetch_word(W_J100, 1);
        accept_instr(0);
        exp_addr_q.push_back(32'h0000_0100);
    endtask

    task automatic resolve_branch(input logic taken);
        jr_valid  = 1'b1;
        jr_target = 32'h0000_0800;
        @(negedge clk);
        jr_valid  = 1'b0;
        total++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL resolve_wait: valid=%b req=%b required 0 0", instr_valid, imem_req);
        end
        br_valid = 1'b1;
        br_taken = taken;
        @(negedge clk);
        br_valid = 1'b0;
        br_taken = 1'b0;
    endtask

    task automatic test_branch;
        fetch_word(W_BEQ, 1);
        accept_instr(0);
        resolve_branch(1'b1);
        exp_addr_q.push_back(32'h0000_00FC);
        fetch_word(W_J100, 2);
        accept_instr(0);
        exp_addr_q.push_back(32'h0000_0100);
        fetch_word(W_BEQ, 0);
        accept_instr(0);
        resolve_branch(1'b0);
        // Stray resolution inputs while fetching must not move the PC.
        br_valid = 1'b1;
        br_taken = 1'b1;
        jr_valid = 1'b1;
        repeat (3) @(negedge clk);
        br_valid = 1'b0;
        br_taken = 1'b0;
        jr_valid = 1'b0;
        exp_addr_q.push_back(32'h0000_0104);
    endtask

    task automatic test_jr_backpressure;
        fetch_word(W_JR, 1);
        accept_instr(3);
        br_valid = 1'b1;
        br_taken = 1'b1;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL jr_ignores_br: req=%b valid=%b required 0 0", imem_req, instr_valid);
        end
        jr_valid  = 1'b1;
        jr_target = 32'h0000_2003;
        @(negedge clk);
        jr_valid  = 1'b0;
        br_valid  = 1'b0;
        br_taken  = 1'b0;
        exp_addr_q.push_back(32'h0000_2000);
    endtask

    task automatic test_wrap_and_reset;
        bit ok;
        fetch_word(W_JR, 1);
        accept_instr(0);
        jr_valid  = 1'b1;
        jr_target = 32'hFFFF_FFFF;
        @(negedge clk);
        jr_valid  = 1'b0;
        exp_addr_q.push_back(32'hFFFF_FFFC);
        fetch_word(W_ADDI, 1);
        accept_instr(0);
        exp_addr_q.push_back(32'h0000_0000);
        fetch_word(W_ADDI, 1);
        accept_instr(0);
        wait_req(ok);
        total++;
        if (!ok || imem_addr !== 32'h0000_0004) begin
            bad++;
            $display("FAIL pre_reset_req: ok=%b addr=%h required 1 00000004", ok, imem_addr);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0000_0000) begin
            bad++;
            $display("FAIL async_reset: req=%b addr=%h required 0 00000000", imem_req, imem_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_illegal;
        bit seen_valid, seen_req;
        exp_addr_q.push_back(32'h0000_0000);
        fetch_word(W_ILL, 1);
        exp_pc_q.delete();
        exp_word_q.delete();
        seen_valid = 1'b0;
        seen_req   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (instr_valid) seen_valid = 1'b1;
            if (imem_req)    seen_req   = 1'b1;
            @(negedge clk);
        end
        total++;
        if (illegal_op !== 1'b1 || seen_valid || seen_req) begin
            bad++;
            $display("FAIL illegal_halt: ill=%b valid_seen=%b req_seen=%b required 1 0 0", illegal_op, seen_valid, seen_req);
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        total++;
        if (illegal_op !== 1'b0) begin
            bad++;
            $display("FAIL illegal_clear: ill=%b required 0", illegal_op);
        end
        exp_addr_q.push_back(32'h0000_0000);
        fetch_word(W_ADDI, 0);
        accept_instr(0);
        exp_addr_q.push_back(32'h0000_0004);
        fetch_word(W_ADDI, 0);
        accept_instr(0);
    endtask

    initial begin
        reset_n     = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        instr_ready = 1'b0;
        br_valid    = 1'b0;
        br_taken    = 1'b0;
        jr_valid    = 1'b0;
        jr_target   = 32'd0;
        test_reset;
        test_sequential;
        test_jal;
        test_branch;
        test_jr_backpressure;
        test_wrap_and_reset;
        test_illegal;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
